// File: rtl/pygmy_intf_typedef.sv
// Oursring channel payload types shared by every ring master and slave.
package pygmy_intf_typedef;

    typedef struct packed {
        logic [11:0] awid;
        logic [39:0] awaddr;
    } oursring_req_if_aw_t;

    typedef struct packed {
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        wlast;
    } oursring_req_if_w_t;

    typedef struct packed {
        logic [11:0] arid;
        logic [39:0] araddr;
    } oursring_req_if_ar_t;

    typedef struct packed {
        logic [11:0] rid;
        logic [63:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
    } oursring_resp_if_r_t;

    typedef struct packed {
        logic [11:0] bid;
        logic [1:0]  bresp;
    } oursring_resp_if_b_t;

endpackage

// File: rtl/pygmy_typedef.sv
// Common enums, response codes and request checks for the pygmy bridges.
package pygmy_typedef;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_ISSUE = 2'd1,
        WR_ERR   = 2'd2
    } wr_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // The ring only carries single beats of at most 32 bits.
    function automatic logic req_legal(input logic [3:0] len, input logic [2:0] size);
        return (len == 4'd0) && (size <= 3'd2);
    endfunction

endpackage

// File: rtl/ours_lane_fifo.sv
// 1-bit tag FIFO remembering which 32-bit lane each in-flight ring read targets.
module ours_lane_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DEPTH-1:0] mem;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Extra pointer bit tells a full ring of entries from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ours_conv_32_to_oursring_64.sv
// Bridges a 32-bit single-beat AXI initiator onto the 64-bit oursring request/response ports.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; valid never waits on ready.
module ours_conv_32_to_oursring_64
    import pygmy_typedef::*;
    import pygmy_intf_typedef::*;
#(
    parameter int RD_OUTSTANDING = 4,
    parameter int WR_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [11:0]         s_awid,
    input  logic [39:0]         s_awaddr,
    input  logic [3:0]          s_awlen,
    input  logic [2:0]          s_awsize,
    input  logic                s_wvalid,
    output logic                s_wready,
    input  logic [31:0]         s_wdata,
    input  logic [3:0]          s_wstrb,
    input  logic                s_wlast,
    output logic                s_bvalid,
    input  logic                s_bready,
    output logic [11:0]         s_bid,
    output logic [1:0]          s_bresp,
    input  logic                s_arvalid,
    output logic                s_arready,
    input  logic [11:0]         s_arid,
    input  logic [39:0]         s_araddr,
    input  logic [3:0]          s_arlen,
    input  logic [2:0]          s_arsize,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic [11:0]         s_rid,
    output logic [31:0]         s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic                or_req_if_awvalid,
    input  logic                or_req_if_awready,
    output oursring_req_if_aw_t or_req_if_aw,
    output logic                or_req_if_wvalid,
    input  logic                or_req_if_wready,
    output oursring_req_if_w_t  or_req_if_w,
    output logic                or_req_if_arvalid,
    input  logic                or_req_if_arready,
    output oursring_req_if_ar_t or_req_if_ar,
    input  logic                or_resp_if_rvalid,
    output logic                or_resp_if_rready,
    input  oursring_resp_if_r_t or_resp_if_r,
    input  logic                or_resp_if_bvalid,
    output logic                or_resp_if_bready,
    input  oursring_resp_if_b_t or_resp_if_b,
    output logic                err_unexp,
    output logic [1:0]          dbg_wr_state
);

    localparam int WCW = $clog2(WR_OUTSTANDING + 1);
    localparam logic [WCW-1:0] WR_MAX  = WCW'(WR_OUTSTANDING);
    localparam logic [WCW-1:0] WCNT_ONE = WCW'(1);

    wr_state_e      wr_state;
    logic           live;
    logic           aw_held, w_held, aw_pend, w_pend;
    logic [11:0]    aw_id;
    logic [39:0]    aw_addr;
    logic [3:0]     aw_len;
    logic [2:0]     aw_size;
    logic [31:0]    w_data;
    logic [3:0]     w_strb;
    logic [WCW-1:0] wr_cnt;
    logic           ar_held;
    logic [11:0]    ar_id;
    logic [39:0]    ar_addr;
    logic [3:0]     ar_len;
    logic [2:0]     ar_size;
    logic           fifo_full, fifo_empty, lane_head;
    logic           unused_wlast;

    // live holds every ready low until the first edge after reset is released.
    logic wr_zero, err_b_sel, ring_aw_hs, ring_w_hs, ring_b_dec, unexp_b;
    logic ar_legal, err_r_sel, ring_ar_hs, ring_r_pop, unexp_r;

    assign unused_wlast = s_wlast;
    assign dbg_wr_state = wr_state;

    assign wr_zero    = (wr_cnt == '0);
    assign s_awready  = live && (wr_state == WR_IDLE) && !aw_held;
    assign s_wready   = live && (wr_state == WR_IDLE) && !w_held;

    assign or_req_if_awvalid = aw_pend;
    assign or_req_if_wvalid  = w_pend;
    assign or_req_if_aw      = '{awid: aw_id, awaddr: aw_addr};
    assign or_req_if_w       = '{wdata: {w_data, w_data},
                                 wstrb: aw_addr[2] ? {w_strb, 4'h0} : {4'h0, w_strb},
                                 wlast: 1'b1};
    assign ring_aw_hs = aw_pend && or_req_if_awready;
    assign ring_w_hs  = w_pend && or_req_if_wready;

    // The local error response is only presented once all ring writes have drained.
    assign err_b_sel         = (wr_state == WR_ERR) && wr_zero;
    assign s_bvalid          = err_b_sel || (or_resp_if_bvalid && !wr_zero);
    assign s_bid             = err_b_sel ? aw_id : or_resp_if_b.bid;
    assign s_bresp           = err_b_sel ? AXI_RESP_SLVERR : or_resp_if_b.bresp;
    assign or_resp_if_bready = live && (wr_zero || s_bready);
    assign ring_b_dec        = or_resp_if_bvalid && !wr_zero && s_bready;
    assign unexp_b           = live && or_resp_if_bvalid && wr_zero;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_state <= WR_IDLE;
            live     <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_pend  <= 1'b0;
            w_pend   <= 1'b0;
            aw_id    <= '0;
            aw_addr  <= '0;
            aw_len   <= '0;
            aw_size  <= '0;
            w_data   <= '0;
            w_strb   <= '0;
        end else begin
            live <= 1'b1;
            if (s_awvalid && s_awready) begin
                aw_held <= 1'b1;
                aw_id   <= s_awid;
                aw_addr <= s_awaddr;
                aw_len  <= s_awlen;
                aw_size <= s_awsize;
            end
            if (s_wvalid && s_wready) begin
                w_held <= 1'b1;
                w_data <= s_wdata;
                w_strb <= s_wstrb;
            end
            case (wr_state)
                WR_IDLE: begin
                    if (aw_held && w_held) begin
                        if (!req_legal(aw_len, aw_size)) begin
                            wr_state <= WR_ERR;
                        end else if (wr_cnt != WR_MAX) begin
                            wr_state <= WR_ISSUE;
                            aw_pend  <= 1'b1;
                            w_pend   <= 1'b1;
                        end
                    end
                end
                WR_ISSUE: begin
                    if (ring_aw_hs) aw_pend <= 1'b0;
                    if (ring_w_hs)  w_pend  <= 1'b0;
                    if ((ring_aw_hs || !aw_pend) && (ring_w_hs || !w_pend)) begin
                        wr_state <= WR_IDLE;
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                    end
                end
                WR_ERR: begin
                    if (err_b_sel && s_bready) begin
                        wr_state <= WR_IDLE;
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_cnt <= '0;
        end else if (ring_aw_hs && !ring_b_dec) begin
            wr_cnt <= wr_cnt + WCNT_ONE;
        end else if (!ring_aw_hs && ring_b_dec) begin
            wr_cnt <= wr_cnt - WCNT_ONE;
        end
    end

    assign ar_legal          = req_legal(ar_len, ar_size);
    assign s_arready         = live && !ar_held && !fifo_full;
    assign or_req_if_arvalid = ar_held && ar_legal;
    assign or_req_if_ar      = '{arid: ar_id, araddr: ar_addr};
    assign ring_ar_hs        = or_req_if_arvalid && or_req_if_arready;

    // An illegal read answers locally only after earlier ring reads returned, keeping R in order.
    assign err_r_sel         = ar_held && !ar_legal && fifo_empty;
    assign s_rvalid          = err_r_sel || (or_resp_if_rvalid && !fifo_empty);
    assign s_rid             = err_r_sel ? ar_id : or_resp_if_r.rid;
    assign s_rdata           = err_r_sel ? 32'h0 :
                               (lane_head ? or_resp_if_r.rdata[63:32] : or_resp_if_r.rdata[31:0]);
    assign s_rresp           = err_r_sel ? AXI_RESP_SLVERR : or_resp_if_r.rresp;
    assign s_rlast           = err_r_sel ? 1'b1 : or_resp_if_r.rlast;
    assign or_resp_if_rready = live && (fifo_empty || s_rready);
    assign ring_r_pop        = or_resp_if_rvalid && !fifo_empty && s_rready;
    assign unexp_r           = live && or_resp_if_rvalid && fifo_empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ar_held   <= 1'b0;
            ar_id     <= '0;
            ar_addr   <= '0;
            ar_len    <= '0;
            ar_size   <= '0;
            err_unexp <= 1'b0;
        end else begin
            if (s_arvalid && s_arready) begin
                ar_held <= 1'b1;
                ar_id   <= s_arid;
                ar_addr <= s_araddr;
                ar_len  <= s_arlen;
                ar_size <= s_arsize;
            end else if (ring_ar_hs || (err_r_sel && s_rready)) begin
                ar_held <= 1'b0;
            end
            if (unexp_b || unexp_r) err_unexp <= 1'b1;
        end
    end

    ours_lane_fifo #(
        .DEPTH (RD_OUTSTANDING)
    ) u_lane_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (ring_ar_hs),
        .din   (ar_addr[2]),
        .pop   (ring_r_pop),
        .dout  (lane_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_ours_conv_32_to_oursring_64.sv
// Directed bench for the 32-bit AXI to oursring bridge; the bench plays both the initiator and the ring.
module tb_ours_conv_32_to_oursring_64;
    import pygmy_intf_typedef::*;

    logic                clk;
    logic                rstn;
    logic                s_awvalid, s_awready;
    logic [11:0]         s_awid;
    logic [39:0]         s_awaddr;
    logic [3:0]          s_awlen;
    logic [2:0]          s_awsize;
    logic                s_wvalid, s_wready;
    logic [31:0]         s_wdata;
    logic [3:0]          s_wstrb;
    logic                s_wlast;
    logic                s_bvalid, s_bready;
    logic [11:0]         s_bid;
    logic [1:0]          s_bresp;
    logic                s_arvalid, s_arready;
    logic [11:0]         s_arid;
    logic [39:0]         s_araddr;
    logic [3:0]          s_arlen;
    logic [2:0]          s_arsize;
    logic                s_rvalid, s_rready;
    logic [11:0]         s_rid;
    logic [31:0]         s_rdata;
    logic [1:0]          s_rresp;
    logic                s_rlast;
    logic                or_req_if_awvalid, or_req_if_awready;
    oursring_req_if_aw_t or_req_if_aw;
    logic                or_req_if_wvalid, or_req_if_wready;
    oursring_req_if_w_t  or_req_if_w;
    logic                or_req_if_arvalid, or_req_if_arready;
    oursring_req_if_ar_t or_req_if_ar;
    logic                or_resp_if_rvalid, or_resp_if_rready;
    oursring_resp_if_r_t or_resp_if_r;
    logic                or_resp_if_bvalid, or_resp_if_bready;
    oursring_resp_if_b_t or_resp_if_b;
    logic                err_unexp;
    logic [1:0]          dbg_wr_state;

    int n_checks = 0;
    int n_err    = 0;
    int aw_hs_cnt = 0;
    int w_hs_cnt  = 0;
    int aw0, w0;

    logic [10:0] vr_vec;
    assign vr_vec = {s_awready, s_wready, s_arready, s_rvalid, s_bvalid,
                     or_req_if_awvalid, or_req_if_wvalid, or_req_if_arvalid,
                     or_resp_if_rready, or_resp_if_bready, err_unexp};

    ours_conv_32_to_oursring_64 #(
        .RD_OUTSTANDING (4),
        .WR_OUTSTANDING (4)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .s_awvalid         (s_awvalid),
        .s_awready         (s_awready),
        .s_awid            (s_awid),
        .s_awaddr          (s_awaddr),
        .s_awlen           (s_awlen),
        .s_awsize          (s_awsize),
        .s_wvalid          (s_wvalid),
        .s_wready          (s_wready),
        .s_wdata           (s_wdata),
        .s_wstrb           (s_wstrb),
        .s_wlast           (s_wlast),
        .s_bvalid          (s_bvalid),
        .s_bready          (s_bready),
        .s_bid             (s_bid),
        .s_bresp           (s_bresp),
        .s_arvalid         (s_arvalid),
        .s_arready         (s_arready),
        .s_arid            (s_arid),
        .s_araddr          (s_araddr),
        .s_arlen           (s_arlen),
        .s_arsize          (s_arsize),
        .s_rvalid          (s_rvalid),
        .s_rready          (s_rready),
        .s_rid             (s_rid),
        .s_rdata           (s_rdata),
        .s_rresp           (s_rresp),
        .s_rlast           (s_rlast),
        .or_req_if_awvalid (or_req_if_awvalid),
        .or_req_if_awready (or_req_if_awready),
        .or_req_if_aw      (or_req_if_aw),
        .or_req_if_wvalid  (or_req_if_wvalid),
        .or_req_if_wready  (or_req_if_wready),
        .or_req_if_w       (or_req_if_w),
        .or_req_if_arvalid (or_req_if_arvalid),
        .or_req_if_arready (or_req_if_arready),
        .or_req_if_ar      (or_req_if_ar),
        .or_resp_if_rvalid (or_resp_if_rvalid),
        .or_resp_if_rready (or_resp_if_rready),
        .or_resp_if_r      (or_resp_if_r),
        .or_resp_if_bvalid (or_resp_if_bvalid),
        .or_resp_if_bready (or_resp_if_bready),
        .or_resp_if_b      (or_resp_if_b),
        .err_unexp         (err_unexp),
        .dbg_wr_state      (dbg_wr_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (or_req_if_awvalid && or_req_if_awready) aw_hs_cnt <= aw_hs_cnt + 1;
        if (or_req_if_wvalid && or_req_if_wready)   w_hs_cnt  <= w_hs_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_aw(input logic [11:0] id, input logic [39:0] addr,
                           input logic [3:0] len, input logic [2:0] size);
        int cyc = 0;
        s_awvalid = 1'b1; s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = size;
        #1;
        while (!s_awready && cyc < 40) begin tick(); cyc++; end
        chk("aw_accept", s_awready, 1);
        tick();
        s_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        int cyc = 0;
        s_wvalid = 1'b1; s_wdata = data; s_wstrb = strb; s_wlast = 1'b1;
        #1;
        while (!s_wready && cyc < 40) begin tick(); cyc++; end
        chk("w_accept", s_wready, 1);
        tick();
        s_wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [11:0] id, input logic [39:0] addr,
                           input logic [3:0] len, input logic [2:0] size);
        int cyc = 0;
        s_arvalid = 1'b1; s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size;
        #1;
        while (!s_arready && cyc < 40) begin tick(); cyc++; end
        chk("ar_accept", s_arready, 1);
        tick();
        s_arvalid = 1'b0;
    endtask

    task automatic ring_take_aw(input logic [11:0] id, input logic [39:0] addr);
        int cyc = 0;
        while (!or_req_if_awvalid && cyc < 40) begin tick(); cyc++; end
        chk("ring_awvalid", or_req_if_awvalid, 1);
        chk("ring_awid", or_req_if_aw.awid, id);
        chk("ring_awaddr", or_req_if_aw.awaddr, addr);
        or_req_if_awready = 1'b1;
        tick();
        or_req_if_awready = 1'b0;
    endtask

    task automatic ring_take_w(input logic [63:0] data, input logic [7:0] strb);
        int cyc = 0;
        while (!or_req_if_wvalid && cyc < 40) begin tick(); cyc++; end
        chk("ring_wvalid", or_req_if_wvalid, 1);
        chk("ring_wdata", or_req_if_w.wdata, data);
        chk("ring_wstrb", or_req_if_w.wstrb, strb);
        chk("ring_wlast", or_req_if_w.wlast, 1);
        or_req_if_wready = 1'b1;
        tick();
        or_req_if_wready = 1'b0;
    endtask

    task automatic ring_take_ar(input logic [11:0] id, input logic [39:0] addr);
        int cyc = 0;
        while (!or_req_if_arvalid && cyc < 40) begin tick(); cyc++; end
        chk("ring_arvalid", or_req_if_arvalid, 1);
        chk("ring_arid", or_req_if_ar.arid, id);
        chk("ring_araddr", or_req_if_ar.araddr, addr);
        or_req_if_arready = 1'b1;
        tick();
        or_req_if_arready = 1'b0;
    endtask

    task automatic ring_give_b(input logic [11:0] id, input logic [1:0] resp);
        int cyc = 0;
        or_resp_if_bvalid = 1'b1;
        or_resp_if_b = '{bid: id, bresp: resp};
        #1;
        while (!or_resp_if_bready && cyc < 40) begin tick(); cyc++; end
        chk("b_fwd_valid", s_bvalid, 1);
        chk("b_fwd_id", s_bid, id);
        chk("b_fwd_resp", s_bresp, resp);
        tick();
        or_resp_if_bvalid = 1'b0;
    endtask

    task automatic ring_give_r(input logic [11:0] id, input logic [63:0] data, input logic [31:0] exp_data);
        int cyc = 0;
        or_resp_if_rvalid = 1'b1;
        or_resp_if_r = '{rid: id, rdata: data, rresp: 2'b00, rlast: 1'b1};
        #1;
        while (!or_resp_if_rready && cyc < 40) begin tick(); cyc++; end
        chk("r_fwd_valid", s_rvalid, 1);
        chk("r_fwd_id", s_rid, id);
        chk("r_fwd_data", s_rdata, exp_data);
        chk("r_fwd_last", s_rlast, 1);
        tick();
        or_resp_if_rvalid = 1'b0;
    endtask

    initial begin
        rstn = 1'b1;
        s_awvalid = 0; s_awid = 0; s_awaddr = 0; s_awlen = 0; s_awsize = 0;
        s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0;
        s_bready = 0; s_arvalid = 0; s_arid = 0; s_araddr = 0; s_arlen = 0; s_arsize = 0;
        s_rready = 0;
        or_req_if_awready = 0; or_req_if_wready = 0; or_req_if_arready = 0;
        or_resp_if_rvalid = 0; or_resp_if_r = '0; or_resp_if_bvalid = 0; or_resp_if_b = '0;
        #1 rstn = 1'b0;
        #2;
        chk("reset_vr", vr_vec, 11'h0);
        chk("reset_state", dbg_wr_state, 2'd0);
        tick(); tick();
        rstn = 1'b1;
        tick();
        chk("post_reset_ready", {s_awready, s_wready, s_arready}, 3'b111);
        s_bready = 1'b1;
        s_rready = 1'b1;

        // Basic write to the upper lane.
        send_aw(12'h123, 40'h1004, 4'd0, 3'd2);
        send_w(32'hA5A5_1234, 4'hF);
        ring_take_aw(12'h123, 40'h1004);
        ring_take_w(64'hA5A51234_A5A51234, 8'hF0);
        ring_give_b(12'h123, 2'b00);
        #1;
        chk("b_single", s_bvalid, 0);

        // Four reads fill the lane FIFO; the fifth waits for the first R.
        for (int i = 0; i < 4; i++) begin
            send_ar(12'h200 + 12'(i), 40'(i * 4), 4'd0, 3'd2);
            ring_take_ar(12'h200 + 12'(i), 40'(i * 4));
        end
        s_arvalid = 1'b1; s_arid = 12'h204; s_araddr = 40'h10; s_arlen = 0; s_arsize = 3'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ar_blocked_full", s_arready, 0);
            tick();
        end
        ring_give_r(12'h200, 64'h11112222_33334444, 32'h33334444);
        chk("ar_unblocked", s_arready, 1);
        tick();
        s_arvalid = 1'b0;
        ring_take_ar(12'h204, 40'h10);
        ring_give_r(12'h201, 64'h11112222_33334444, 32'h11112222);
        ring_give_r(12'h202, 64'h11112222_33334444, 32'h33334444);
        ring_give_r(12'h203, 64'h11112222_33334444, 32'h11112222);
        ring_give_r(12'h204, 64'hDEADBEEF_CAFEF00D, 32'hCAFEF00D);
        #1;
        chk("r_drained", s_rvalid, 0);

        // Illegal write waits for the outstanding ring write's B.
        send_aw(12'h0A1, 40'h2000, 4'd0, 3'd2);
        send_w(32'h0000_0055, 4'h1);
        ring_take_aw(12'h0A1, 40'h2000);
        ring_take_w(64'h00000055_00000055, 8'h01);
        send_aw(12'h0B2, 40'h3000, 4'd3, 3'd2);
        send_w(32'h0000_0066, 4'hF);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("err_wr_quiet", {or_req_if_awvalid, or_req_if_wvalid, s_bvalid}, 3'b000);
        end
        chk("err_state", dbg_wr_state, 2'd2);
        ring_give_b(12'h0A1, 2'b00);
        #1;
        chk("err_b_valid", s_bvalid, 1);
        chk("err_b_id", s_bid, 12'h0B2);
        chk("err_b_resp", s_bresp, 2'b10);
        tick();
        chk("err_b_done", s_bvalid, 0);
        chk("err_back_idle", dbg_wr_state, 2'd0);

        // W arrives well before AW; ring AW is stalled after W completes.
        aw0 = aw_hs_cnt;
        w0  = w_hs_cnt;
        send_w(32'h0BAD_F00D, 4'h3);
        tick(); tick();
        send_aw(12'h0C3, 40'h4000, 4'd0, 3'd1);
        ring_take_w(64'h0BADF00D_0BADF00D, 8'h03);
        for (int i = 0; i < 5; i++) begin
            chk("aw_held_w_done", {or_req_if_awvalid, or_req_if_wvalid}, 2'b10);
            tick();
        end
        ring_take_aw(12'h0C3, 40'h4000);
        tick(); tick(); tick();
        chk("aw_once", aw_hs_cnt - aw0, 1);
        chk("w_once", w_hs_cnt - w0, 1);
        ring_give_b(12'h0C3, 2'b00);

        // Reset in the middle of issuing a write.
        begin
            int cyc = 0;
            send_aw(12'h0D4, 40'h5008, 4'd0, 3'd2);
            send_w(32'h0000_0077, 4'hF);
            while (!or_req_if_awvalid && cyc < 40) begin tick(); cyc++; end
        end
        chk("issue_state", dbg_wr_state, 2'd1);
        rstn = 1'b0;
        #1;
        chk("midreset_vr", vr_vec, 11'h0);
        chk("midreset_state", dbg_wr_state, 2'd0);
        tick(); tick();
        rstn = 1'b1;
        tick(); tick();
        aw0 = aw_hs_cnt;
        chk("rerun_awready", s_awready, 1);
        tick(); tick(); tick();
        chk("no_stale_resp", {s_bvalid, or_req_if_awvalid, or_req_if_wvalid}, 3'b000);
        send_aw(12'h0E5, 40'h6004, 4'd0, 3'd2);
        send_w(32'h1234_5678, 4'h5);
        ring_take_aw(12'h0E5, 40'h6004);
        ring_take_w(64'h12345678_12345678, 8'h50);
        ring_give_b(12'h0E5, 2'b00);
        chk("rerun_aw_once", aw_hs_cnt - aw0, 1);

        // Illegal read with an empty FIFO, held until s_rready.
        s_rready = 1'b0;
        send_ar(12'h0F6, 40'h7000, 4'd0, 3'd3);
        #1;
        chk("rerr_valid", s_rvalid, 1);
        chk("rerr_id", s_rid, 12'h0F6);
        chk("rerr_data", s_rdata, 32'h0);
        chk("rerr_resp_last", {s_rresp, s_rlast}, 3'b101);
        chk("rerr_not_fwd", or_req_if_arvalid, 0);
        tick();
        chk("rerr_hold", s_rvalid, 1);
        s_rready = 1'b1;
        tick();
        chk("rerr_done", {s_rvalid, s_arready}, 2'b01);

        // Illegal read behind a legal one answers only after the ring R.
        send_ar(12'h101, 40'h8004, 4'd0, 3'd2);
        ring_take_ar(12'h101, 40'h8004);
        send_ar(12'h102, 40'h9000, 4'd1, 3'd2);
        tick(); tick();
        chk("rerr_wait", {s_rvalid, or_req_if_arvalid}, 2'b00);
        ring_give_r(12'h101, 64'hAAAABBBB_CCCCDDDD, 32'hAAAABBBB);
        #1;
        chk("rerr2_valid", s_rvalid, 1);
        chk("rerr2_id", s_rid, 12'h102);
        chk("rerr2_resp", s_rresp, 2'b10);
        tick();
        chk("rerr2_done", s_rvalid, 0);
        chk("no_unexp_yet", err_unexp, 0);

        // Stray ring responses are swallowed and flagged.
        or_resp_if_rvalid = 1'b1;
        or_resp_if_r = '{rid: 12'h3FF, rdata: 64'h1, rresp: 2'b00, rlast: 1'b1};
        #1;
        chk("unexp_r_drop", {or_resp_if_rready, s_rvalid}, 2'b10);
        tick();
        or_resp_if_rvalid = 1'b0;
        chk("unexp_flag", err_unexp, 1);
        or_resp_if_bvalid = 1'b1;
        or_resp_if_b = '{bid: 12'h3FE, bresp: 2'b00};
        #1;
        chk("unexp_b_drop", {or_resp_if_bready, s_bvalid}, 2'b10);
        tick();
        or_resp_if_bvalid = 1'b0;
        tick();
        chk("unexp_sticky", err_unexp, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
